tick_sequencer: RTL and testbench
=================================

TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 SHALL provide parameter MIN_GAP, default 200001: minimum legal clock cycles between consecutive tick pulses.
REQ-002 SHALL provide parameter MAX_GAP, default 200001: maximum legal clock cycles from a tick, or from the end of reset, without a tick.
REQ-003 SHALL provide parameters RED_T, GREEN_T and YELLOW_T, defaults 3, 2 and 1: phase durations in ticks, each at least 1.
REQ-004 SHALL provide parameter CBITS, default 18: gap-counter width, with 2^CBITS-1 at least MAX_GAP.
REQ-005 clk  input  1  sole clock; all state updates on posedge.
REQ-006 rst  input  1  asynchronous, active-low reset; asserting it (low) resets all state immediately.
REQ-007 tick  input  1  one-cycle pulse from the upstream period-delay stage (its sig output).
REQ-008 red  output  1  RED phase indicator.
REQ-009 green  output  1  GREEN phase indicator.
REQ-010 yellow  output  1  YELLOW phase indicator.
REQ-011 early  output  1  one-cycle pulse: tick arrived before MIN_GAP cycles.
REQ-012 late  output  1  one-cycle pulse: MAX_GAP cycles elapsed without a tick.
REQ-013 fault  output  1  sticky error flag; set on early or late.

Function
REQ-014 The FSM SHALL have states IDLE, RED, GREEN, YELLOW and FAULT, encoded in 3 bits.
REQ-015 All outputs SHALL be registered; red, green and yellow SHALL be high exactly in their named state, and all three SHALL be low in IDLE and FAULT.
REQ-016 Gap counter gcnt (CBITS bits) SHALL clear to 0 on a tick cycle, otherwise increment by 1, saturating at 2^CBITS-1.
REQ-017 The measured gap at a tick SHALL be gcnt+1, computed at CBITS+1 bits so it never wraps.
REQ-018 An armed bit SHALL clear on reset and set on the first tick; no early check SHALL apply while armed is 0.
REQ-019 early SHALL pulse on the cycle after any tick where armed is 1 and gap < MIN_GAP; a tick at exactly gap = MIN_GAP SHALL be legal.
REQ-020 late SHALL pulse on the cycle after gcnt reaches MAX_GAP with no tick on that cycle, and SHALL not re-pulse until a later tick.
REQ-021 If a tick coincides with gcnt = MAX_GAP, the tick SHALL win and late SHALL not pulse.
REQ-022 fault SHALL set on the cycle after either condition and SHALL hold until reset; the FSM SHALL enter FAULT on that same cycle.
REQ-023 In FAULT, ticks SHALL be ignored, except that gcnt keeps counting and no further early or late pulses are produced.
REQ-024 Phase tick counter pcnt (2 bits minimum, sized for max(RED_T, GREEN_T, YELLOW_T)) SHALL count ticks within the current phase.
REQ-025 IDLE SHALL go to RED with pcnt=0 on the first legal tick.
REQ-026 In phase X with a legal tick: if pcnt = X_T-1, the FSM SHALL advance (RED to GREEN, GREEN to YELLOW, YELLOW to RED) and clear pcnt; otherwise pcnt SHALL increment.
REQ-027 An early tick SHALL not advance the phase; the FSM SHALL go to FAULT instead.
REQ-028 Without faults, the RED, GREEN, YELLOW cycle SHALL repeat indefinitely, so each light recurs infinitely often under periodic legal ticks.

Reset
REQ-029 While rst is low: state = IDLE; gcnt, pcnt and armed = 0; red, green, yellow, early, late and fault = 0.
REQ-030 Reset asserted mid-phase or in FAULT SHALL abort immediately with no output glitch beyond the asynchronous clear.
REQ-031 On rst deassertion, gcnt SHALL start counting from 0, so late fires if no tick arrives within MAX_GAP cycles.

Verification (bench parameters MIN_GAP=3, MAX_GAP=8, RED_T=3, GREEN_T=2, YELLOW_T=1)
REQ-032 Ticks every 5 cycles from reset SHALL produce the phase sequence RED x3 ticks, GREEN x2, YELLOW x1, RED, with fault=0 throughout.
REQ-033 A tick, then another tick 2 cycles later, SHALL give early=1 for one cycle, fault=1, all lights 0 and state FAULT.
REQ-034 A tick, then another tick exactly 3 cycles later, SHALL give early=0 and the phase advancing normally.
REQ-035 No tick for 8 cycles after a tick SHALL give late=1 for exactly one cycle, fault=1, and fault held for a further 20 cycles despite ticks.
REQ-036 A tick arriving on the cycle gcnt=8 SHALL give late=0 and normal operation.
REQ-037 rst driven low while in GREEN with pcnt=1 SHALL immediately clear all outputs to 0; the next tick after release SHALL enter RED.

Source files
------------

// File: rtl/tick_sequencer_if.sv
// rtl/tick_sequencer_if.sv - tick input and light/status outputs of the tick sequencer
interface tick_sequencer_if;
  logic tick;
  logic red;
  logic green;
  logic yellow;
  logic early;
  logic late;
  logic fault;

  modport master (
    output tick,
    input  red, green, yellow, early, late, fault
  );

  modport slave (
    input  tick,
    output red, green, yellow, early, late, fault
  );
endinterface

// File: rtl/tick_sequencer.sv
// rtl/tick_sequencer.sv - RED/GREEN/YELLOW phase sequencer driven by ticks
// with min/max gap supervision and a sticky fault state.
module tick_sequencer #(
  parameter int unsigned MIN_GAP  = 200001,
  parameter int unsigned MAX_GAP  = 200001,
  parameter int unsigned RED_T    = 3,
  parameter int unsigned GREEN_T  = 2,
  parameter int unsigned YELLOW_T = 1,
  parameter int unsigned CBITS    = 18
) (
  input logic              clk,
  input logic              rst,
  tick_sequencer_if.slave  bus
);

  localparam int unsigned MAXT = (RED_T > GREEN_T) ?
                                 ((RED_T > YELLOW_T) ? RED_T : YELLOW_T) :
                                 ((GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T);
  localparam int unsigned PW   = ($clog2(MAXT) < 2) ? 2 : $clog2(MAXT);

  localparam logic [CBITS-1:0] GCNT_SAT    = {CBITS{1'b1}};
  localparam logic [CBITS-1:0] MAX_GAP_C   = CBITS'(MAX_GAP);
  localparam logic [CBITS:0]   MIN_GAP_C   = (CBITS+1)'(MIN_GAP);
  localparam logic [PW-1:0]    RED_LAST    = PW'(RED_T - 1);
  localparam logic [PW-1:0]    GREEN_LAST  = PW'(GREEN_T - 1);
  localparam logic [PW-1:0]    YELLOW_LAST = PW'(YELLOW_T - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RED    = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CBITS-1:0] gcnt_q, gcnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             armed_q, armed_d;
  logic             late_done_q, late_done_d;
  logic             red_q, red_d;
  logic             green_q, green_d;
  logic             yellow_q, yellow_d;
  logic             early_q, early_d;
  logic             late_q, late_d;
  logic             fault_q, fault_d;

  logic [CBITS:0]   gap;
  logic             tick_live;
  logic             early_hit;
  logic             late_hit;
  logic [PW-1:0]    phase_last;

  always_comb begin
    gap        = (CBITS+1)'(gcnt_q) + (CBITS+1)'(1);
    tick_live  = bus.tick && (state_q != S_FAULT);
    early_hit  = tick_live && armed_q && (gap < MIN_GAP_C);
    // late_done keeps a saturated counter parked on MAX_GAP from re-firing
    late_hit   = !bus.tick && (state_q != S_FAULT) &&
                 (gcnt_q == MAX_GAP_C) && !late_done_q;

    phase_last = RED_LAST;
    case (state_q)
      S_GREEN:  phase_last = GREEN_LAST;
      S_YELLOW: phase_last = YELLOW_LAST;
      default:  phase_last = RED_LAST;
    endcase
  end

  always_comb begin
    gcnt_d      = gcnt_q;
    late_done_d = late_done_q;
    armed_d     = armed_q | tick_live;

    if (bus.tick) begin
      gcnt_d      = '0;
      late_done_d = 1'b0;
    end else begin
      if (gcnt_q != GCNT_SAT) begin
        gcnt_d = gcnt_q + CBITS'(1);
      end
      if (late_hit) begin
        late_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;

    if (early_hit || late_hit) begin
      state_d = S_FAULT;
    end else if (tick_live) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RED;
          pcnt_d  = '0;
        end
        S_RED, S_GREEN, S_YELLOW: begin
          if (pcnt_q == phase_last) begin
            pcnt_d = '0;
            case (state_q)
              S_RED:   state_d = S_GREEN;
              S_GREEN: state_d = S_YELLOW;
              default: state_d = S_RED;
            endcase
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end

    red_d    = (state_d == S_RED);
    green_d  = (state_d == S_GREEN);
    yellow_d = (state_d == S_YELLOW);
    early_d  = early_hit;
    late_d   = late_hit;
    fault_d  = fault_q | early_hit | late_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gcnt_q      <= '0;
      pcnt_q      <= '0;
      armed_q     <= 1'b0;
      late_done_q <= 1'b0;
      red_q       <= 1'b0;
      green_q     <= 1'b0;
      yellow_q    <= 1'b0;
      early_q     <= 1'b0;
      late_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      pcnt_q      <= pcnt_d;
      armed_q     <= armed_d;
      late_done_q <= late_done_d;
      red_q       <= red_d;
      green_q     <= green_d;
      yellow_q    <= yellow_d;
      early_q     <= early_d;
      late_q      <= late_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.red    = red_q;
  assign bus.green  = green_q;
  assign bus.yellow = yellow_q;
  assign bus.early  = early_q;
  assign bus.late   = late_q;
  assign bus.fault  = fault_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// tb/tb_tick_sequencer.sv - directed and randomized checks of tick_sequencer
// against a timestamp-based reference model.
module tb_tick_sequencer;
  localparam int MIN_GAP  = 3;
  localparam int MAX_GAP  = 8;
  localparam int RED_T    = 3;
  localparam int GREEN_T  = 2;
  localparam int YELLOW_T = 1;
  localparam int CYCLE_T  = RED_T + GREEN_T + YELLOW_T;

  logic clk;
  logic rst;
  tick_sequencer_if bus ();

  tick_sequencer #(
    .MIN_GAP (MIN_GAP),
    .MAX_GAP (MAX_GAP),
    .RED_T   (RED_T),
    .GREEN_T (GREEN_T),
    .YELLOW_T(YELLOW_T),
    .CBITS   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: cycle stamps and a count of legal ticks; phase derived by modulo.
  int cyc;
  int last;
  bit armed, fault, late_done;
  int legal;
  bit e_early, e_late, e_red, e_green, e_yellow;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".red"},    bus.red,    e_red);
    chk({tag, ".green"},  bus.green,  e_green);
    chk({tag, ".yellow"}, bus.yellow, e_yellow);
    chk({tag, ".early"},  bus.early,  e_early);
    chk({tag, ".late"},   bus.late,   e_late);
    chk({tag, ".fault"},  bus.fault,  fault);
  endtask

  task automatic model_reset();
    cyc = 0; last = -1; armed = 0; fault = 0; late_done = 0; legal = 0;
    e_early = 0; e_late = 0; e_red = 0; e_green = 0; e_yellow = 0;
  endtask

  task automatic model_edge(input bit t);
    int elapsed;
    int p;
    elapsed = cyc - last;
    e_early = 0;
    e_late  = 0;
    if (!fault) begin
      if (t) begin
        if (armed && elapsed < MIN_GAP) e_early = 1;
        else legal++;
        armed = 1;
      end else if (elapsed - 1 == MAX_GAP && !late_done) begin
        e_late    = 1;
        late_done = 1;
      end
    end
    if (t) begin
      last      = cyc;
      late_done = 0;
    end
    fault = fault | e_early | e_late;
    e_red = 0; e_green = 0; e_yellow = 0;
    if (!fault && legal > 0) begin
      p = (legal - 1) % CYCLE_T;
      if (p < RED_T) e_red = 1;
      else if (p < RED_T + GREEN_T) e_green = 1;
      else e_yellow = 1;
    end
    cyc++;
  endtask

  task automatic step(input bit t, input string tag);
    bus.tick = t;
    @(posedge clk);
    model_edge(t);
    #1;
    chk_all(tag);
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic gap_tick(input int d, input string tag);
    for (int i = 1; i < d; i++) step(1'b0, tag);
    step(1'b1, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    model_reset();
    #1;
    chk_all({tag, ".in_reset"});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int g;
    rst = 1'b0;
    bus.tick = 1'b0;
    model_reset();
    @(negedge clk);
    chk_all("por");
    @(negedge clk);
    rst = 1'b1;

    // periodic legal ticks through more than one full light cycle
    step(1'b1, "periodic");
    for (int k = 0; k < 13; k++) gap_tick(5, "periodic");
    for (int i = 0; i < 4; i++) step(1'b0, "periodic_tail");

    do_reset("early");
    step(1'b1, "early");
    gap_tick(2, "early");
    for (int i = 0; i < 4; i++) gap_tick(4, "early_after");

    do_reset("min_gap");
    step(1'b1, "min_gap");
    for (int k = 0; k < 6; k++) gap_tick(MIN_GAP, "min_gap");

    do_reset("late");
    step(1'b1, "late");
    for (int i = 0; i < 12; i++) step(1'b0, "late_wait");
    for (int i = 0; i < 5; i++) gap_tick(4, "late_hold");

    do_reset("tick_at_max");
    step(1'b1, "tick_at_max");
    gap_tick(MAX_GAP + 1, "tick_at_max");
    gap_tick(MAX_GAP + 1, "tick_at_max");
    gap_tick(4, "tick_at_max");

    do_reset("late_from_reset");
    for (int i = 0; i < 12; i++) step(1'b0, "late_from_reset");

    do_reset("green_abort");
    step(1'b1, "green_abort");
    for (int k = 0; k < 4; k++) gap_tick(5, "green_abort");
    chk("green_abort.pre_green", bus.green, 1'b1);
    step(1'b0, "green_abort");
    do_reset("green_abort");
    step(1'b0, "green_abort_release");
    step(1'b1, "green_abort_release");
    chk("green_abort.red_after", bus.red, 1'b1);

    for (int ep = 0; ep < 8; ep++) begin
      do_reset("rand");
      step(1'b1, "rand");
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 9) < 8) g = $urandom_range(MIN_GAP, MAX_GAP + 1);
        else g = $urandom_range(1, MAX_GAP + 4);
        gap_tick(g, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
